// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures ROM data into a valid/ready IR.
// Optional FETCH_HALT_EN: an all-ones instruction word stops fetching (HALT state).
module fetch_unit #(
    parameter int          PC_W     = 8,
    parameter int          INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int          CNT_W    = 16
) (
    input  logic               clk,
    input  logic               power,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] code,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               branch_en,
    input  logic [PC_W-1:0]    next_pc,
    output logic [CNT_W-1:0]   fetch_count,
    output logic               halted
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
`ifdef FETCH_HALT_EN
        ,
        HALT  = 2'd3
`endif
    } state_t;

    state_t state;

    logic fire;
    logic slot_free;

    assign fire      = ir_valid & ir_ready;
    assign slot_free = !ir_valid || ir_ready;

`ifndef FETCH_HALT_EN
    assign halted = 1'b0;
`endif

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge power) begin
        if (!power) begin
            state       <= BOOT;
            pc          <= PC_W'(RESET_PC);
            ir          <= '0;
            ir_pc       <= '0;
            ir_valid    <= 1'b0;
            fetch_count <= '0;
`ifdef FETCH_HALT_EN
            halted      <= 1'b0;
`endif
        end else begin
            // A handshake counts in any state, including the cycle of a branch.
            if (fire) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end

            case (state)
                BOOT: begin
                    state <= RUN;
                end

                RUN, STALL: begin
                    if (branch_en) begin
                        pc       <= next_pc;
                        ir_valid <= 1'b0;
                        state    <= RUN;
                    end else if (slot_free) begin
                        ir       <= code;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        pc       <= pc + PC_W'(1);
                        state    <= RUN;
`ifdef FETCH_HALT_EN
                        if (code == {INSTR_W{1'b1}}) begin
                            state <= HALT;
                        end
`endif
                    end else begin
                        state <= STALL;
                    end
                end

`ifdef FETCH_HALT_EN
                // Frozen: the halt word may still drain, nothing else moves.
                HALT: begin
                    halted <= 1'b1;
                    if (fire) begin
                        ir_valid <= 1'b0;
                    end
                end
`endif

                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational ROM model.
module tb_fetch_unit;

    logic        clk;
    logic        power;
    logic [7:0]  pc;
    logic [15:0] code;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        branch_en;
    logic [7:0]  next_pc;
    logic [15:0] fetch_count;
    logic        halted;

    logic [15:0] rom [256];

    int vectors;
    int miscompares;

    fetch_unit dut (
        .clk         (clk),
        .power       (power),
        .pc          (pc),
        .code        (code),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .branch_en   (branch_en),
        .next_pc     (next_pc),
        .fetch_count (fetch_count),
        .halted      (halted)
    );

    assign code = rom[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ir(input string tag, input logic [15:0] e_ir, input logic [7:0] e_ir_pc,
                            input logic e_valid, input logic [7:0] e_pc, input logic [15:0] e_cnt);
        check({tag, ".ir"},       32'(ir),          32'(e_ir));
        check({tag, ".ir_pc"},    32'(ir_pc),       32'(e_ir_pc));
        check({tag, ".ir_valid"}, 32'(ir_valid),    32'(e_valid));
        check({tag, ".pc"},       32'(pc),          32'(e_pc));
        check({tag, ".count"},    32'(fetch_count), 32'(e_cnt));
    endtask

    task automatic check_reset(input string tag);
        check_ir(tag, 16'h0000, 8'h00, 1'b0, 8'h00, 16'd0);
        check({tag, ".halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'hA000 | 16'(i);
        rom[0] = 16'h1111;
        rom[1] = 16'h2222;
        rom[2] = 16'h3333;
        rom[3] = 16'h4444;

        power     = 1'b0;
        ir_ready  = 1'b1;
        branch_en = 1'b0;
        next_pc   = 8'h00;

        #2;
        check_reset("reset");
        #10;
        power = 1'b1;

        // Edge 1: BOOT, nothing fetched yet.
        step();
        check_ir("boot", 16'h0000, 8'h00, 1'b0, 8'h00, 16'd0);
        step();
        check_ir("e2", 16'h1111, 8'h00, 1'b1, 8'h01, 16'd0);
        step();
        check_ir("e3", 16'h2222, 8'h01, 1'b1, 8'h02, 16'd1);

        // Backpressure on 2222 for three edges.
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ir("stall", 16'h2222, 8'h01, 1'b1, 8'h02, 16'd1);
        end
        ir_ready = 1'b1;
        step();
        check_ir("unstall", 16'h3333, 8'h02, 1'b1, 8'h03, 16'd2);
        step();
        check_ir("e8", 16'h4444, 8'h03, 1'b1, 8'h04, 16'd3);

        // Branch while ir is valid and consumed: fire counts, ir flushed.
        branch_en = 1'b1;
        next_pc   = 8'h40;
        step();
        branch_en = 1'b0;
        check_ir("br_flush", 16'h4444, 8'h03, 1'b0, 8'h40, 16'd4);
        step();
        check_ir("br_tgt", 16'hA040, 8'h40, 1'b1, 8'h41, 16'd4);

        // Self-loop on 8'h41, pulsed every other cycle.
        branch_en = 1'b1;
        next_pc   = 8'h41;
        step();
        branch_en = 1'b0;
        check_ir("loop1_flush", 16'hA040, 8'h40, 1'b0, 8'h41, 16'd5);
        step();
        check_ir("loop1", 16'hA041, 8'h41, 1'b1, 8'h42, 16'd5);
        branch_en = 1'b1;
        step();
        branch_en = 1'b0;
        check_ir("loop2_flush", 16'hA041, 8'h41, 1'b0, 8'h41, 16'd6);
        step();
        check_ir("loop2", 16'hA041, 8'h41, 1'b1, 8'h42, 16'd6);

        // PC wrap from FE through 01.
        branch_en = 1'b1;
        next_pc   = 8'hFE;
        step();
        branch_en = 1'b0;
        check_ir("wrap_flush", 16'hA041, 8'h41, 1'b0, 8'hFE, 16'd7);
        step();
        check_ir("wrap_fe", 16'hA0FE, 8'hFE, 1'b1, 8'hFF, 16'd7);
        step();
        check_ir("wrap_ff", 16'hA0FF, 8'hFF, 1'b1, 8'h00, 16'd8);
        step();
        check_ir("wrap_00", 16'h1111, 8'h00, 1'b1, 8'h01, 16'd9);
        step();
        check_ir("wrap_01", 16'h2222, 8'h01, 1'b1, 8'h02, 16'd10);

        // Stall, then async reset between edges with a branch pending.
        ir_ready = 1'b0;
        step();
        check_ir("pre_rst", 16'h2222, 8'h01, 1'b1, 8'h02, 16'd10);
        #2;
        power     = 1'b0;
        branch_en = 1'b1;
        next_pc   = 8'h55;
        #1;
        check_reset("async_rst");
        #1;
        power    = 1'b1;
        ir_ready = 1'b1;
        step();
        check_ir("reboot", 16'h0000, 8'h00, 1'b0, 8'h00, 16'd0);
        branch_en = 1'b0;
        step();
        check_ir("refetch", 16'h1111, 8'h00, 1'b1, 8'h01, 16'd0);

        // All-ones word at address 2.
        rom[2] = 16'hFFFF;
        power  = 1'b0;
        #1;
        power  = 1'b1;
        step();
        step();
        step();
        check_ir("h_e3", 16'h2222, 8'h01, 1'b1, 8'h02, 16'd1);
        step();
        check_ir("h_cap", 16'hFFFF, 8'h02, 1'b1, 8'h03, 16'd2);
        check("h_cap.halted", 32'(halted), 32'd0);
        branch_en = 1'b1;
        next_pc   = 8'h80;
        step();
`ifdef FETCH_HALT_EN
        check_ir("h_halt", 16'hFFFF, 8'h02, 1'b0, 8'h03, 16'd3);
        check("h_halt.halted", 32'(halted), 32'd1);
        branch_en = 1'b0;
        step();
        check_ir("h_frozen", 16'hFFFF, 8'h02, 1'b0, 8'h03, 16'd3);
        check("h_frozen.halted", 32'(halted), 32'd1);
`else
        branch_en = 1'b0;
        check_ir("h_ordinary_br", 16'hFFFF, 8'h02, 1'b0, 8'h80, 16'd3);
        step();
        check_ir("h_ordinary", 16'hA080, 8'h80, 1'b1, 8'h81, 16'd3);
        check("h_ordinary.halted", 32'(halted), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
